// File: rtl/instr_mem_pkg.sv
`default_nettype none
// =============================================================================
// Module   : instr_mem_pkg
// Purpose  : Shared loader state type and stream constants for instr_mem_loader.
// Revision : 1.0
// =============================================================================
package instr_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } load_state_t;

   localparam int HDR_BYTES = 4;

   function automatic logic loader_active(input load_state_t s);
      return (s == ST_HDR) || (s == ST_DATA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// =============================================================================
// Module   : instr_ram
// Purpose  : Single-port synchronous RAM, registered read, unreset array.
// Revision : 1.0
// =============================================================================
module instr_ram #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

   // No reset anywhere here so the array and read register map onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            r_mem[addr] <= wdata;
         end else begin
            rdata <= r_mem[addr];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// =============================================================================
// Module   : instr_mem_loader
// Purpose  : Instruction RAM with a length-prefixed byte-stream loader and a
//            ready/valid processor fetch port.
// Revision : 1.0
// =============================================================================
module instr_mem_loader
   import instr_mem_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_fault
);

   localparam int c_BYTES = DATA_W / 8;
   localparam int c_LB    = $clog2(c_BYTES);
   localparam int c_CNT_W = (c_BYTES > HDR_BYTES) ? $clog2(c_BYTES) : $clog2(HDR_BYTES);

   load_state_t         r_state;
   logic [c_CNT_W-1:0]  r_byte_cnt;
   logic [ADDR_W:0]     r_word_cnt;
   logic [ADDR_W:0]     r_word_tot;
   logic [23:0]         r_hdr;
   logic [DATA_W-1:0]   r_shift;
   logic                r_done;
   logic                r_err;

   logic                r_pend;
   logic                r_pend_fault;
   logic                r_fetch_valid;
   logic [DATA_W-1:0]   r_fetch_data;
   logic                r_fetch_fault;

   logic                w_rx_ready;
   logic                w_rx_fire;
   logic                w_last_hdr;
   logic                w_last_lane;
   logic [31:0]         w_hdr_count;
   logic                w_too_big;
   logic [ADDR_W:0]     w_word_next;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_we;
   logic                w_misaligned;
   logic                w_out_of_range;
   logic                w_fault;
   logic                w_fetch_ready;
   logic                w_fetch_fire;
   logic                w_ram_en;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic [DATA_W-1:0]   w_rdata;

   // ---------------------------------------------------------------- decode
   assign w_rx_ready  = loader_active(r_state);
   assign w_rx_fire   = rx_valid && w_rx_ready && !load_start;
   assign w_last_hdr  = (r_byte_cnt == c_CNT_W'(HDR_BYTES - 1));
   assign w_last_lane = (r_byte_cnt == c_CNT_W'(c_BYTES - 1));
   assign w_hdr_count = {rx_data, r_hdr};
   assign w_too_big   = {1'b0, w_hdr_count} > (33'd1 << ADDR_W);
   assign w_word_next = r_word_cnt + 1'b1;
   assign w_we        = (r_state == ST_DATA) && w_rx_fire && w_last_lane;

   always_comb begin
      w_wdata = r_shift;
      w_wdata[8*r_byte_cnt +: 8] = rx_data;
   end

   generate
      if (c_LB > 0) begin : g_align
         assign w_misaligned = |fetch_addr[c_LB-1:0];
      end else begin : g_align_none
         assign w_misaligned = 1'b0;
      end

      if (ADDR_W + c_LB < 32) begin : g_range
         assign w_out_of_range = |fetch_addr[31:ADDR_W+c_LB];
      end else begin : g_range_none
         assign w_out_of_range = 1'b0;
      end
   endgenerate

   assign w_fault       = w_misaligned || w_out_of_range;
   assign w_fetch_ready = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !load_start;
   assign w_fetch_fire  = fetch_req && w_fetch_ready;

   // Writes only happen in DATA and fetches only in IDLE/DONE, so the port never collides.
   assign w_ram_en   = w_we || (w_fetch_fire && !w_fault);
   assign w_ram_addr = w_we ? r_word_cnt[ADDR_W-1:0] : fetch_addr[c_LB +: ADDR_W];

   instr_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .en    (w_ram_en),
      .we    (w_we),
      .addr  (w_ram_addr),
      .wdata (w_wdata),
      .rdata (w_rdata)
   );

   // ---------------------------------------------------------------- loader
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_byte_cnt <= '0;
         r_word_cnt <= '0;
         r_word_tot <= '0;
         r_hdr      <= '0;
         r_shift    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else if (load_start) begin
         r_state    <= ST_HDR;
         r_byte_cnt <= '0;
         r_word_cnt <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_HDR: begin
               if (w_rx_fire) begin
                  r_hdr <= {rx_data, r_hdr[23:8]};
                  if (w_last_hdr) begin
                     r_byte_cnt <= '0;
                     r_word_tot <= w_hdr_count[ADDR_W:0];
                     if (w_hdr_count == 32'd0) begin
                        r_state <= ST_DONE;
                     end else if (w_too_big) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                     end else begin
                        r_state <= ST_DATA;
                     end
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_rx_fire) begin
                  r_shift <= w_wdata;
                  if (w_last_lane) begin
                     r_byte_cnt <= '0;
                     r_word_cnt <= w_word_next;
                     if (w_word_next == r_word_tot) begin
                        r_state <= ST_DONE;
                     end
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end
            // load_done follows entry into DONE by one edge.
            ST_DONE: r_done <= 1'b1;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- fetch response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend        <= 1'b0;
         r_pend_fault  <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_fetch_data  <= '0;
         r_fetch_fault <= 1'b0;
      end else begin
         r_pend        <= w_fetch_fire;
         r_pend_fault  <= w_fault;
         r_fetch_valid <= r_pend;
         r_fetch_fault <= r_pend && r_pend_fault;
         if (r_pend) begin
            r_fetch_data <= r_pend_fault ? '0 : w_rdata;
         end
      end
   end

   assign rx_ready    = w_rx_ready;
   assign load_busy   = w_rx_ready;
   assign load_done   = r_done;
   assign load_err    = r_err;
   assign fetch_ready = w_fetch_ready;
   assign fetch_valid = r_fetch_valid;
   assign fetch_data  = r_fetch_data;
   assign fetch_fault = r_fetch_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// =============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Self-checking bench for instr_mem_loader against a word-array model.
// Revision : 1.0
// =============================================================================
module tb_instr_mem_loader;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        load_start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        load_busy;
   logic        load_done;
   logic        load_err;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = 32'h0;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_fault;

   int vectors = 0;
   int miscompares = 0;
   int hi_word = 0;
   logic [31:0] model [int];

   instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .load_start  (load_start),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .load_busy   (load_busy),
      .load_done   (load_done),
      .load_err    (load_err),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Spec-level view of a fetch: aligned and inside 4*DEPTH bytes, otherwise a fault.
   function automatic logic exp_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] a);
      if (exp_fault(a)) return 32'h0;
      return model[int'(a >> 2)];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int i;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      rx_data  = b;
      rx_valid = 1'b1;
      i = 0;
      while (rx_ready !== 1'b1 && i < 50) begin
         step();
         i++;
      end
      vectors++;
      if (rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rx_ready_wait: got %b want 1", rx_ready);
      end
      step();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      while (load_done !== 1'b1 && i < 20) begin
         step();
         i++;
      end
      vectors++;
      if (load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL load_done_wait: got %b want 1", load_done);
      end
   endtask

   task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output logic f);
      int i;
      fetch_addr = a;
      fetch_req  = 1'b1;
      i = 0;
      while (fetch_ready !== 1'b1 && i < 50) begin
         step();
         i++;
      end
      vectors++;
      if (fetch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL fetch_ready_wait: got %b want 1", fetch_ready);
      end
      step();
      fetch_req = 1'b0;
      vectors++;
      if (fetch_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_early_valid: got %b want 0", fetch_valid);
      end
      step();
      vectors++;
      if (fetch_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL fetch_valid: got %b want 1", fetch_valid);
      end
      d = fetch_data;
      f = fetch_fault;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step();
      step();
      vectors++;
      if ({rx_ready, load_busy, load_done, load_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_loader: got %b want 0000", {rx_ready, load_busy, load_done, load_err});
      end
      vectors++;
      if ({fetch_ready, fetch_valid, fetch_fault} !== 3'b100 || fetch_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_fetch: got rdy/vld/flt=%b data=%h want 100 data=0",
                  {fetch_ready, fetch_valid, fetch_fault}, fetch_data);
      end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_first_fetch();
      logic [31:0] d;
      logic f;
      do_fetch(32'h0, d, f);
      vectors++;
      if (f !== 1'b0) begin
         miscompares++;
         $display("FAIL first_fetch_fault: got %b want 0", f);
      end
      step();
      vectors++;
      if (fetch_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_pulse_width: got %b want 0", fetch_valid);
      end
   endtask

   task automatic test_basic_load();
      logic [31:0] d;
      logic f;
      logic [7:0] bytes [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      pulse_start();
      for (int k = 0; k < 12; k++) send_byte(bytes[k], 1'b0);
      wait_done();
      model[0] = 32'h12345678;
      model[1] = 32'hDEADBEEF;
      if (hi_word < 2) hi_word = 2;
      vectors++;
      if ({load_err, load_busy, rx_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL basic_flags: got err/busy/rdy=%b want 000", {load_err, load_busy, rx_ready});
      end
      do_fetch(32'h0, d, f);
      vectors++;
      if (d !== 32'h12345678 || f !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_word0: got %h/%b want 12345678/0", d, f);
      end
      do_fetch(32'h4, d, f);
      vectors++;
      if (d !== 32'hDEADBEEF || f !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_word1: got %h/%b want deadbeef/0", d, f);
      end
   endtask

   task automatic test_overflow_header();
      logic [31:0] d;
      logic f;
      logic [31:0] n;
      n = 32'(DEPTH + 1);
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b1);
      wait_done();
      vectors++;
      if ({load_err, load_done, rx_ready} !== 3'b110) begin
         miscompares++;
         $display("FAIL overflow_flags: got err/done/rdy=%b want 110", {load_err, load_done, rx_ready});
      end
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      step();
      step();
      vectors++;
      if (rx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL done_rx_ready: got %b want 0", rx_ready);
      end
      rx_valid = 1'b0;
      do_fetch(32'h0, d, f);
      vectors++;
      if (d !== exp_data(32'h0)) begin
         miscompares++;
         $display("FAIL overflow_mem0: got %h want %h", d, exp_data(32'h0));
      end
      do_fetch(32'h4, d, f);
      vectors++;
      if (d !== exp_data(32'h4)) begin
         miscompares++;
         $display("FAIL overflow_mem1: got %h want %h", d, exp_data(32'h4));
      end
   endtask

   task automatic test_zero_count();
      pulse_start();
      vectors++;
      if ({load_done, load_err, load_busy} !== 3'b001) begin
         miscompares++;
         $display("FAIL start_clears: got done/err/busy=%b want 001", {load_done, load_err, load_busy});
      end
      for (int k = 0; k < 4; k++) send_byte(8'h00, 1'b1);
      wait_done();
      vectors++;
      if (load_err !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_count_err: got %b want 0", load_err);
      end
   endtask

   task automatic test_faults();
      logic [31:0] d;
      logic [31:0] a;
      logic f;
      for (int k = 0; k < 6; k++) begin
         if (k == 0)      a = 32'h2;
         else if (k == 1) a = 32'h1 << (ADDR_W + 2);
         else begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'($urandom_range(1, 3));
            else a[$urandom_range(ADDR_W + 2, 31)] = 1'b1;
         end
         do_fetch(a, d, f);
         vectors++;
         if (f !== exp_fault(a) || d !== 32'h0) begin
            miscompares++;
            $display("FAIL fault_addr %h: got fault=%b data=%h want fault=%b data=0", a, f, d, exp_fault(a));
         end
      end
   endtask

   task automatic test_fetch_stall();
      logic [31:0] w [3];
      logic [7:0] b [$];
      for (int k = 0; k < 3; k++) w[k] = $urandom;
      b = {8'h03, 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 4; j++) b.push_back(w[k][8*j +: 8]);
      pulse_start();
      fetch_addr = 32'h0;
      fetch_req  = 1'b1;
      for (int k = 0; k < b.size(); k++) begin
         rx_data  = b[k];
         rx_valid = 1'b1;
         vectors++;
         if (fetch_ready !== 1'b0 || fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_byte%0d: got rdy=%b vld=%b want 0 0", k, fetch_ready, fetch_valid);
         end
         step();
      end
      rx_valid = 1'b0;
      for (int k = 0; k < 3; k++) model[k] = w[k];
      if (hi_word < 3) hi_word = 3;
      vectors++;
      if (fetch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_first_done: got rdy=%b want 1", fetch_ready);
      end
      step();
      fetch_req = 1'b0;
      vectors++;
      if (load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_done_rise: got %b want 1", load_done);
      end
      step();
      vectors++;
      if (fetch_valid !== 1'b1 || fetch_data !== w[0]) begin
         miscompares++;
         $display("FAIL stall_resp: got vld=%b data=%h want 1 %h", fetch_valid, fetch_data, w[0]);
      end
   endtask

   task automatic test_restart();
      logic [31:0] d;
      logic [31:0] nw;
      logic f;
      // fetch accepted immediately before a load_start must still respond
      fetch_addr = 32'h4;
      fetch_req  = 1'b1;
      step();
      fetch_req  = 1'b0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      vectors++;
      if (fetch_valid !== 1'b1 || fetch_data !== model[1]) begin
         miscompares++;
         $display("FAIL pre_start_fetch: got vld=%b data=%h want 1 %h", fetch_valid, fetch_data, model[1]);
      end
      for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'h02 : 8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      pulse_start();
      nw = $urandom;
      for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'h01 : 8'h00, 1'b1);
      send_word(nw, 1'b1);
      wait_done();
      model[0] = nw;
      do_fetch(32'h0, d, f);
      vectors++;
      if (d !== nw) begin
         miscompares++;
         $display("FAIL restart_word0: got %h want %h", d, nw);
      end
      do_fetch(32'h4, d, f);
      vectors++;
      if (d !== model[1]) begin
         miscompares++;
         $display("FAIL restart_word1: got %h want %h", d, model[1]);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      logic [31:0] wa;
      logic [31:0] wb;
      logic f;
      wa = $urandom;
      wb = $urandom;
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'h02 : 8'h00, 1'b0);
      send_word(wa, 1'b0);
      send_byte(wb[7:0], 1'b0);
      model[0] = wa;
      #2 rstn = 1'b0;
      #1;
      vectors++;
      if ({load_busy, rx_ready, load_done} !== 3'b000 || fetch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset: got busy/rdy/done=%b frdy=%b want 000 1",
                  {load_busy, rx_ready, load_done}, fetch_ready);
      end
      step();
      rstn = 1'b1;
      step();
      do_fetch(32'h0, d, f);
      vectors++;
      if (d !== wa) begin
         miscompares++;
         $display("FAIL async_keep0: got %h want %h", d, wa);
      end
      do_fetch(32'h4, d, f);
      vectors++;
      if (d !== model[1]) begin
         miscompares++;
         $display("FAIL async_keep1: got %h want %h", d, model[1]);
      end
   endtask

   task automatic test_random_loads();
      logic [31:0] d;
      logic [31:0] a;
      logic [31:0] w [$];
      logic f;
      int n;
      for (int it = 0; it < 5; it++) begin
         n = $urandom_range(1, 6);
         w.delete();
         for (int k = 0; k < n; k++) w.push_back($urandom);
         pulse_start();
         for (int k = 0; k < 4; k++) send_byte(8'((n >> (8 * k)) & 255), 1'b1);
         for (int k = 0; k < n; k++) send_word(w[k], 1'b1);
         wait_done();
         for (int k = 0; k < n; k++) model[k] = w[k];
         if (hi_word < n) hi_word = n;
         vectors++;
         if (load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_err it%0d: got %b want 0", it, load_err);
         end
         for (int q = 0; q < 3; q++) begin
            a = 32'($urandom_range(0, hi_word - 1)) << 2;
            do_fetch(a, d, f);
            vectors++;
            if (d !== exp_data(a) || f !== exp_fault(a)) begin
               miscompares++;
               $display("FAIL rand_fetch %h: got %h/%b want %h/%b", a, d, f, exp_data(a), exp_fault(a));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [8];
      for (int k = 0; k < 8; k++) begin
         a[k] = 32'($urandom_range(0, hi_word - 1)) << 2;
         if (k == 5) a[k] = a[k] | 32'h1;
      end
      fetch_addr = a[0];
      fetch_req  = 1'b1;
      vectors++;
      if (fetch_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ready: got %b want 1", fetch_ready);
      end
      for (int k = 0; k < 9; k++) begin
         step();
         if (k >= 1) begin
            vectors++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp_data(a[k-1]) ||
                fetch_fault !== exp_fault(a[k-1])) begin
               miscompares++;
               $display("FAIL b2b_resp%0d: got %b/%h/%b want 1/%h/%b", k - 1, fetch_valid,
                        fetch_data, fetch_fault, exp_data(a[k-1]), exp_fault(a[k-1]));
            end
         end
         if (k + 1 < 8) fetch_addr = a[k+1];
         else fetch_req = 1'b0;
      end
      step();
      vectors++;
      if (fetch_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_tail: got %b want 0", fetch_valid);
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_basic_load();
      test_overflow_header();
      test_zero_count();
      test_faults();
      test_fetch_stall();
      test_restart();
      test_async_reset();
      test_random_loads();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised instruction memory with an on-chip byte-stream loader and a processor fetch port. It generalises the fixed 32 Kword, IO/processor-muxed instruction RAM. Width and depth are now parameters. A loader FSM assembles a length-prefixed byte stream from the UART receiver into words and writes them sequentially. Processor fetches use a ready/valid handshake that stalls while a load is in progress. It sits between the UART RX path and the core's IF stage.

## Interface
- `ADDR_W`, 15: word-address bits; depth = 2^ADDR_W words.
- `DATA_W`, 32: word width; must be a multiple of 8; BYTES = DATA_W/8.
- `clk` in 1: sole clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `load_start` in 1: one-cycle pulse that begins (or restarts) a load session.
- `rx_data` in 8: loader byte.
- `rx_valid` in 1: byte present.
- `rx_ready` out 1: loader accepts a byte; a transfer happens when `rx_valid && rx_ready`.
- `load_busy` out 1: high in HDR or DATA.
- `load_done` out 1: sticky; set on session end, cleared by `load_start`.
- `load_err` out 1: sticky; set when the header count exceeds depth, cleared by `load_start`.
- `fetch_req` in 1: processor fetch request.
- `fetch_addr` in 32: byte address.
- `fetch_ready` out 1: fetch accepted when `fetch_req && fetch_ready`.
- `fetch_valid` out 1: one-cycle pulse; the response is present.
- `fetch_data` out DATA_W: fetched word.
- `fetch_fault` out 1: qualifies `fetch_valid`; the address was misaligned or out of range.

## Operation
- States: IDLE, HDR, DATA, DONE. Reset state is IDLE.
- `load_start` in any state moves to HDR. It clears the byte counter, the word counter, `load_done` and `load_err`. It takes priority over every other event in that cycle.
- HDR:
  - Accepts 4 bytes, little-endian, forming the 32-bit word count N.
  - After the 4th byte: if N == 0, go to DONE. If N > 2^ADDR_W, go to DONE with `load_err`=1 and write nothing. Otherwise go to DATA.
- DATA:
  - Bytes are assembled little-endian; byte k lands in bits [8k+7:8k].
  - When BYTES bytes are held, the word is written at word index = word counter, and the counter increments.
  - After the Nth write, go to DONE.
- DONE: `load_done`=1. It returns to HDR only on `load_start`. Extra stream bytes are not accepted (`rx_ready`=0).
- `rx_ready` = 1 in HDR and DATA only.
- `fetch_ready` = (state ∈ {IDLE, DONE}) && !`load_start`.
- Fetch checks:
  - Misaligned: `fetch_addr`[log2(BYTES)-1:0] ≠ 0.
  - Out of range: any `fetch_addr` bit above ADDR_W+log2(BYTES)-1 is set.
  - Either condition gives a fault response with `fetch_data`=0 and no RAM read.
- A RAM read and a RAM write never occur in the same cycle, because fetches are refused during HDR/DATA.
- RAM contents are not reset. They survive `rstn` and are overwritten only by loads.

## Timing
- Reset values:
  - `rx_ready`=0, `load_busy`=0, `load_done`=0, `load_err`=0.
  - `fetch_ready`=1 (IDLE), `fetch_valid`=0, `fetch_data`=0, `fetch_fault`=0.
- Fetch latency is 1 cycle: a request accepted at edge t gives `fetch_valid` for exactly one cycle after edge t+1. Back-to-back requests give one response per cycle.
- `fetch_data` holds its last value until the next response.
- A fetch accepted in the cycle before `load_start` still completes with `fetch_valid` one cycle later.
- Word write latency: the RAM write occurs on the same edge that accepts the final byte of the word.
- DATA → DONE transition: `load_done` rises on the edge after the last write's edge.
- HDR → DONE transition (N == 0 or N > 2^ADDR_W): `load_done` rises on the edge after the 4th header byte.
- `rx_valid` gaps of any length are tolerated in HDR/DATA; no timeout.
- Asynchronous reset mid-load returns to IDLE immediately. A partially assembled word is discarded, and words already written remain.

## Structure
- Shared package `instr_mem_pkg` holds the loader state enum and the `HDR_BYTES`=4 constant.
- One sub-module, `instr_ram`: single-port synchronous RAM of 2^ADDR_W × DATA_W with `we`, `en`, registered read, and no reset on the array, so it infers block RAM.
- The top level holds the FSM, the byte/word counters, the shift register, the address decode and the response register.

## Test plan
- Reset, then fetch 0x0 → `fetch_ready`=1; `fetch_valid`=1 one cycle later with `fetch_fault`=0.
- `load_start`, then bytes 02 00 00 00 78 56 34 12 EF BE AD DE → `load_done`=1. Fetch 0x0 returns 0x12345678; fetch 0x4 returns 0xDEADBEEF.
- Header count 2^ADDR_W+1 → `load_err`=1, `load_done`=1, memory unchanged, `rx_ready`=0.
- Fetch 0x2 gives a fault. Fetch with bit ADDR_W+2 set gives a fault. Both return `fetch_data`=0.
- `fetch_req` held high during DATA → `fetch_ready`=0 and no `fetch_valid`. The fetch is accepted in the first DONE cycle.
- `load_start` pulsed after 2 data bytes, then a fresh 1-word stream → only the new word is written at index 0; the partial bytes are discarded.
